// File: rtl/timer_pkg.sv
// Shared definitions for the tick timer / interrupt scheduler: register map,
// control/config bit positions and the arbiter state encoding.
package timer_pkg;

    localparam logic [3:0] AddrCtrl     = 4'd0;
    localparam logic [3:0] AddrPrescale = 4'd1;
    localparam logic [3:0] AddrCount    = 4'd2;
    localparam logic [3:0] AddrPending  = 4'd3;
    localparam logic [3:0] AddrChBase   = 4'd4;

    localparam int unsigned ChStride     = 3;
    localparam int unsigned ChCmpOffs    = 0;
    localparam int unsigned ChPeriodOffs = 1;
    localparam int unsigned ChCfgOffs    = 2;

    localparam int unsigned CtrlEnBit     = 0;
    localparam int unsigned CtrlClrBit    = 1;
    localparam int unsigned CfgChEnBit    = 0;
    localparam int unsigned CfgPeriodicBit = 1;

    typedef enum logic [1:0] {
        StIdle,
        StPresent,
        StGap
    } arb_state_t;

    function automatic logic [3:0] ch_addr(input int unsigned ch, input int unsigned offs);
        return AddrChBase + 4'(ChStride * ch) + 4'(offs);
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare channel: CMP/PERIOD/CFG registers, match detect against the
// post-tick count, and periodic reload or one-shot self-disable.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [CW-1:0] count_next,
    input  logic          we_cmp,
    input  logic          we_period,
    input  logic          we_cfg,
    input  logic [CW-1:0] wdata,
    output logic [CW-1:0] cmp,
    output logic [CW-1:0] period,
    output logic [1:0]    cfg,
    output logic          match
);

    logic [CW-1:0] cmp_q, cmp_d, period_q;
    logic [1:0]    cfg_q, cfg_d;
    logic          reload;

    assign match  = tick && cfg_q[CfgChEnBit] && (cmp_q == count_next);
    assign reload = cfg_q[CfgPeriodicBit] && (period_q != '0);

    // Bus writes are applied last so they override the hardware update.
    always_comb begin
        cmp_d = cmp_q;
        cfg_d = cfg_q;
        if (match) begin
            if (reload) begin
                cmp_d = cmp_q + period_q;
            end else begin
                cfg_d[CfgChEnBit] = 1'b0;
            end
        end
        if (we_cmp) begin
            cmp_d = wdata;
        end
        if (we_cfg) begin
            cfg_d = wdata[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q    <= '0;
            period_q <= '0;
            cfg_q    <= '0;
        end else begin
            cmp_q <= cmp_d;
            cfg_q <= cfg_d;
            if (we_period) begin
                period_q <= wdata;
            end
        end
    end

    assign cmp    = cmp_q;
    assign period = period_q;
    assign cfg    = cfg_q;

endmodule

// File: rtl/timer_sched.sv
// Tick timer with prescaler, free-running counter, N compare channels and a
// fixed-priority interrupt presenter with acknowledge handshake.
module timer_sched
    import timer_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CW           = 16,
    parameter int unsigned PRESCALE_RST = 75000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        irq,
    output logic [1:0]  irq_id,
    input  logic        irq_ack
);

    logic          en_q;
    logic [CW-1:0] prescale_q, pcnt_q, count_q, count_inc, wdata_cw;
    logic          wr_ctrl, wr_prescale, wr_pending, clr, tick, tick_eff;

    logic [N_CH-1:0] pending_q, pending_d, match;
    logic [CW-1:0]   ch_cmp    [N_CH];
    logic [CW-1:0]   ch_period [N_CH];
    logic [1:0]      ch_cfg    [N_CH];

    arb_state_t state_q, state_d;
    logic       irq_q, irq_d, ack_fire, pend_cur;
    logic [1:0] irq_id_q, irq_id_d, lowest;
    logic [15:0] rdata_q, rdata_d;

    assign wdata_cw    = CW'(bus_wdata);
    assign wr_ctrl     = bus_we && (bus_addr == AddrCtrl);
    assign wr_prescale = bus_we && (bus_addr == AddrPrescale);
    assign wr_pending  = bus_we && (bus_addr == AddrPending);
    assign clr         = wr_ctrl && bus_wdata[CtrlClrBit];

    assign tick      = en_q && (pcnt_q == prescale_q);
    // A simultaneous clear suppresses the tick, so no channel can match on it.
    assign tick_eff  = tick && !clr;
    assign count_inc = count_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            prescale_q <= CW'(PRESCALE_RST);
            pcnt_q     <= '0;
            count_q    <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q <= bus_wdata[CtrlEnBit];
            end
            if (wr_prescale) begin
                prescale_q <= wdata_cw;
            end
            if (clr || wr_prescale) begin
                pcnt_q <= '0;
            end else if (en_q) begin
                pcnt_q <= tick ? '0 : pcnt_q + CW'(1);
            end
            if (clr) begin
                count_q <= '0;
            end else if (tick) begin
                count_q <= count_inc;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .CW(CW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_eff),
            .count_next(count_inc),
            .we_cmp    (bus_we && (bus_addr == ch_addr(i, ChCmpOffs))),
            .we_period (bus_we && (bus_addr == ch_addr(i, ChPeriodOffs))),
            .we_cfg    (bus_we && (bus_addr == ch_addr(i, ChCfgOffs))),
            .wdata     (wdata_cw),
            .cmp       (ch_cmp[i]),
            .period    (ch_period[i]),
            .cfg       (ch_cfg[i]),
            .match     (match[i])
        );
    end

    assign ack_fire = (state_q == StPresent) && irq_ack;

    // Clears first, then hardware sets, so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_pending) begin
            pending_d &= ~bus_wdata[N_CH-1:0];
        end
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ack_fire && (irq_id_q == 2'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d |= match;
    end

    always_comb begin
        lowest   = '0;
        pend_cur = 1'b0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest = 2'(i);
            end
        end
        for (int i = 0; i < int'(N_CH); i++) begin
            if (irq_id_q == 2'(i)) begin
                pend_cur = pending_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    state_d  = StPresent;
                    irq_d    = 1'b1;
                    irq_id_d = lowest;
                end
            end
            StPresent: begin
                if (irq_ack || !pend_cur) begin
                    state_d = StGap;
                    irq_d   = 1'b0;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (bus_addr)
            AddrCtrl:     rdata_d[CtrlEnBit] = en_q;
            AddrPrescale: rdata_d = 16'(prescale_q);
            AddrCount:    rdata_d = 16'(count_q);
            AddrPending:  rdata_d = 16'(pending_q);
            default:      rdata_d = '0;
        endcase
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus_addr == ch_addr(i, ChCmpOffs)) begin
                rdata_d = 16'(ch_cmp[i]);
            end
            if (bus_addr == ch_addr(i, ChPeriodOffs)) begin
                rdata_d = 16'(ch_period[i]);
            end
            if (bus_addr == ch_addr(i, ChCfgOffs)) begin
                rdata_d = 16'(ch_cfg[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (bus_re) begin
            rdata_q <= rdata_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = irq_q;
    assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: directed scenarios with literal expectations, then
// randomized bus traffic, all compared every cycle against a behavioural model.
module tb_timer_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [15:0] bus_wdata = '0;
    logic [15:0] bus_rdata;
    logic        irq;
    logic [1:0]  irq_id;
    logic        irq_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    timer_sched #(
        .N_CH(4),
        .CW(16),
        .PRESCALE_RST(75000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .irq      (irq),
        .irq_id   (irq_id),
        .irq_ack  (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain variables, the presenter as
    // "which channel is on the wire (or -1)" plus a one-cycle gap flag.
    bit          m_en;
    logic [15:0] m_pre, m_pcnt, m_count, m_rdata;
    bit   [3:0]  m_pend;
    logic [15:0] m_cmp [4];
    logic [15:0] m_per [4];
    bit          m_chen [4];
    bit          m_perio [4];
    int          m_cur;
    bit          m_gap;
    logic [1:0]  m_lastid;

    function automatic logic [15:0] m_read(input logic [3:0] a);
        int ch, k;
        if (a == 0) return {15'b0, m_en};
        if (a == 1) return m_pre;
        if (a == 2) return m_count;
        if (a == 3) return {12'b0, m_pend};
        ch = (int'(a) - 4) / 3;
        k  = (int'(a) - 4) % 3;
        if (k == 0) return m_cmp[ch];
        if (k == 1) return m_per[ch];
        return {14'b0, m_perio[ch], m_chen[ch]};
    endfunction

    task automatic m_reset();
        m_en = 0; m_pre = 16'(75000); m_pcnt = 0; m_count = 0; m_rdata = 0;
        m_pend = 0; m_cur = -1; m_gap = 0; m_lastid = 0;
        for (int i = 0; i < 4; i++) begin
            m_cmp[i] = 0; m_per[i] = 0; m_chen[i] = 0; m_perio[i] = 0;
        end
    endtask

    task automatic m_step();
        bit tick, clr;
        bit [3:0] hit, old_pend;
        logic [15:0] nc;
        int ch, k;
        tick = m_en && (m_pcnt == m_pre);
        clr  = bus_we && bus_addr == 0 && bus_wdata[1];
        if (bus_re) m_rdata = m_read(bus_addr);
        nc = m_count + 16'd1;
        for (int i = 0; i < 4; i++) begin
            hit[i] = tick && !clr && m_chen[i] && (m_cmp[i] == nc);
            if (hit[i]) begin
                if (m_perio[i] && m_per[i] != 0) m_cmp[i] = m_cmp[i] + m_per[i];
                else m_chen[i] = 0;
            end
        end
        if (bus_we && bus_addr >= 4) begin
            ch = (int'(bus_addr) - 4) / 3;
            k  = (int'(bus_addr) - 4) % 3;
            if (k == 0) m_cmp[ch] = bus_wdata;
            else if (k == 1) m_per[ch] = bus_wdata;
            else begin m_chen[ch] = bus_wdata[0]; m_perio[ch] = bus_wdata[1]; end
        end
        if (clr || (bus_we && bus_addr == 1)) m_pcnt = 0;
        else if (m_en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
        if (clr) m_count = 0;
        else if (tick) m_count = nc;
        if (bus_we && bus_addr == 0) m_en = bus_wdata[0];
        if (bus_we && bus_addr == 1) m_pre = bus_wdata;
        old_pend = m_pend;
        if (bus_we && bus_addr == 3) m_pend = m_pend & ~bus_wdata[3:0];
        if (m_cur >= 0 && irq_ack) m_pend[m_cur] = 0;
        m_pend = m_pend | hit;
        if (m_cur >= 0) begin
            if (irq_ack || !old_pend[m_cur]) begin m_cur = -1; m_gap = 1; end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (old_pend != 0) begin
            for (int i = 3; i >= 0; i--) if (old_pend[i]) m_cur = i;
            m_lastid = 2'(m_cur);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        chk("irq", irq, m_cur >= 0);
        if (m_cur >= 0) chk("irq_id", irq_id, m_lastid);
        chk("bus_rdata", bus_rdata, m_rdata);
    end

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus_we = 1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_we = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] v);
        bus_re = 1; bus_addr = a;
        @(negedge clk);
        bus_re = 0;
        v = bus_rdata;
    endtask

    task automatic ack();
        irq_ack = 1;
        @(negedge clk);
        irq_ack = 0;
    endtask

    task automatic wait_irq(input int maxc);
        bit ok = 0;
        repeat (maxc) begin
            if (irq) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("irq_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] v;
        repeat (2) @(negedge clk);
        rst = 0;

        // Reset values
        rd(1, v); chk("reset_prescale", v, 16'h24F8);
        for (int a = 0; a < 16; a++) begin
            if (a != 1) begin rd(4'(a), v); chk("reset_reg", v, 0); end
        end
        chk("reset_irq", irq, 0);

        // Tick every 4 cycles: 5 ticks in 20 cycles
        wr(1, 3);
        wr(0, 1);
        repeat (20) @(negedge clk);
        rd(2, v); chk("count_after_20", v, 5);

        // Ch0 one-shot at COUNT=3
        wr(0, 2); wr(4, 3); wr(6, 1); wr(0, 1);
        wait_irq(100);
        chk("oneshot_id", irq_id, 0);
        rd(2, v); chk("oneshot_count", v, 3);
        rd(3, v); chk("oneshot_pending", v, 1);
        ack();
        rd(6, v); chk("oneshot_cfg", v, 0);
        rd(3, v); chk("oneshot_pending_clr", v, 0);

        // Ch1 periodic CMP=2 PERIOD=5
        wr(0, 2); wr(7, 2); wr(8, 5); wr(9, 3); wr(0, 1);
        for (int n = 0; n < 3; n++) begin
            wait_irq(100);
            chk("periodic_id", irq_id, 1);
            rd(2, v); chk("periodic_count", v, 16'(2 + 5 * n));
            ack();
        end
        wr(9, 0);

        // Counter wrap with ch2
        wr(0, 2); wr(1, 0); wr(0, 1);
        repeat (65500) @(negedge clk);
        wr(10, 1); wr(11, 3); wr(12, 3);
        wait_irq(100);
        wr(0, 0);
        chk("wrap_id", irq_id, 2);
        rd(10, v); chk("wrap_cmp", v, 4);
        rd(2, v); chk("wrap_count", v, 3);
        ack();
        wr(12, 0);
        repeat (3) @(negedge clk);

        // Simultaneous ch0/ch3 match, lowest first, one-cycle gap
        wr(0, 2); wr(1, 3); wr(4, 2); wr(6, 1); wr(13, 2); wr(15, 1); wr(0, 1);
        wait_irq(100);
        chk("dual_first_id", irq_id, 0);
        ack();
        chk("dual_ack_low", irq, 0);
        @(negedge clk);
        chk("dual_gap_low", irq, 0);
        @(negedge clk);
        chk("dual_second_irq", irq, 1);
        chk("dual_second_id", irq_id, 3);
        ack();
        rd(3, v); chk("dual_pending_clr", v, 0);

        // W1C of bit 3 during ch0 presentation suppresses the second irq
        wr(0, 2); wr(4, 2); wr(6, 1); wr(13, 2); wr(15, 1); wr(0, 1);
        wait_irq(100);
        chk("w1c_first_id", irq_id, 0);
        wr(3, 16'h8);
        ack();
        repeat (4) @(negedge clk);
        chk("w1c_no_irq", irq, 0);
        rd(3, v); chk("w1c_pending", v, 0);

        // Reset while an interrupt is presented
        wr(0, 2); wr(4, 1); wr(6, 1); wr(0, 1);
        wait_irq(100);
        #2 rst = 1;
        @(negedge clk);
        chk("midreset_irq", irq, 0);
        #2 rst = 0;
        @(negedge clk);
        rd(1, v); chk("midreset_prescale", v, 16'h24F8);

        // Randomized traffic
        wr(1, 1);
        wr(0, 1);
        for (int c = 0; c < 3000; c++) begin
            bus_we    = ($urandom_range(0, 3) == 0);
            bus_re    = ($urandom_range(0, 2) == 0);
            bus_addr  = 4'($urandom_range(0, 15));
            bus_wdata = 16'($urandom_range(0, 15));
            if (bus_addr == 0) bus_wdata = ($urandom_range(0, 20) == 0) ? 16'd3 : 16'd1;
            if (bus_addr == 1) bus_wdata = 16'($urandom_range(0, 2));
            if (bus_addr >= 4 && ((int'(bus_addr) - 4) % 3) == 0)
                bus_wdata = m_count + 16'($urandom_range(1, 6));
            irq_ack = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        bus_we = 0; bus_re = 0; irq_ack = 0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
